// File: rtl/onchip_mem_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_reader_pkg
// Description : Shared types and constants for the on-chip memory stream
//               reader: FSM state encoding, default widths and the depth
//               of the output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package onchip_mem_stream_reader_pkg;

    localparam int c_ADDR_W    = 10;
    localparam int c_DATA_W    = 32;
    localparam int c_LEN_W     = c_ADDR_W + 1;

    // Output buffer depth. The credit check in the top and the pointer wrap
    // in the buffer both rely on this being 2.
    localparam int c_BUF_DEPTH = 2;
    localparam int c_CNT_W     = $clog2(c_BUF_DEPTH + 1);
    localparam int c_PTR_W     = $clog2(c_BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/onchip_mem_stream_reader_skid.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_reader_skid
// Description : 2-entry FIFO between the memory read port and the stream
//               source. Push and pop may occur together in any state,
//               including when full (the pop frees the slot the push fills).
//               Optional per-entry sop/eop bits when
//               ONCHIP_MEM_STREAM_READER_PKT_EN is defined.
// Ports       : clk, reset_n       - clock, async active-low reset
//               push, push_data    - write one entry
//               push_sop/eop       - packet markers (PKT_EN only)
//               pop                - consume head entry
//               count              - number of stored entries (0..2)
//               head_data          - oldest entry
//               head_sop/eop       - markers of oldest entry (PKT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_stream_reader_skid
    import onchip_mem_stream_reader_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [DATA_W-1:0]  push_data,
`ifdef ONCHIP_MEM_STREAM_READER_PKT_EN
    input  logic               push_sop,
    input  logic               push_eop,
    output logic               head_sop,
    output logic               head_eop,
`endif
    input  logic               pop,
    output logic [c_CNT_W-1:0] count,
    output logic [DATA_W-1:0]  head_data
);

    logic [DATA_W-1:0]  r_data [c_BUF_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_data[r_wr_ptr] <= push_data;
                r_wr_ptr         <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count     = r_count;
    assign head_data = r_data[r_rd_ptr];

`ifdef ONCHIP_MEM_STREAM_READER_PKT_EN
    logic [c_BUF_DEPTH-1:0] r_sop;
    logic [c_BUF_DEPTH-1:0] r_eop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sop <= '0;
            r_eop <= '0;
        end else if (push) begin
            r_sop[r_wr_ptr] <= push_sop;
            r_eop[r_wr_ptr] <= push_eop;
        end
    end

    assign head_sop = r_sop[r_rd_ptr];
    assign head_eop = r_eop[r_rd_ptr];
`endif

endmodule
`default_nettype wire

// File: rtl/onchip_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_reader
// Description : Avalon-MM read master for a single-port on-chip RAM with
//               fixed 1-cycle read latency. A start command streams a
//               wrap-around window of words out on an Avalon-ST source.
//               A 2-entry buffer plus a credit check on issued reads keeps
//               one beat per cycle with no loss under backpressure.
// Option      : ONCHIP_MEM_STREAM_READER_PKT_EN adds src_startofpacket and
//               src_endofpacket.
// Ports       : clk, reset_n               - clock, async active-low reset
//               start, start_addr, length  - command (sampled in IDLE)
//               busy, done                 - command status
//               mem_*                      - Avalon-MM master to the RAM
//               src_data/valid/ready       - Avalon-ST source
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_stream_reader
    import onchip_mem_stream_reader_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int LEN_W  = c_LEN_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   src_data,
    output logic                src_valid,
`ifdef ONCHIP_MEM_STREAM_READER_PKT_EN
    output logic                src_startofpacket,
    output logic                src_endofpacket,
`endif
    input  logic                src_ready
);

    localparam int unsigned c_MAX_LEN = 2**ADDR_W;
    localparam int          c_OCC_W   = c_CNT_W + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_issue_rem;
    logic [LEN_W-1:0]   r_beat_rem;
    logic               r_inflight;
    logic               r_busy;
    logic               r_done;
    logic               r_clken;

    logic [c_CNT_W-1:0] w_count;
    logic [c_OCC_W-1:0] w_occupancy;
    logic [c_OCC_W-1:0] w_limit;
    logic               w_pop;
    logic               w_len_ok;
    logic               w_accept;
    logic               w_issue;
    logic               w_finish;

    // Command accept, read issue and completion decode.
    always_comb begin
        w_pop       = src_valid & src_ready;
        w_len_ok    = (length != '0) && (32'(length) <= c_MAX_LEN);
        // r_done blocks a start arriving in the cycle that done is shown.
        w_accept    = (r_state == ST_IDLE) && start && !r_done && w_len_ok;
        // Credit: buffered + in-flight - popped must leave room for one more.
        w_occupancy = {1'b0, w_count} + c_OCC_W'(r_inflight);
        w_limit     = c_OCC_W'(c_BUF_DEPTH) + c_OCC_W'(w_pop);
        w_issue     = (r_state == ST_RUN) && (r_issue_rem != '0) &&
                      (w_occupancy < w_limit);
        w_finish    = (r_state == ST_DRAIN) &&
                      ((r_beat_rem == '0) || (w_pop && (r_beat_rem == LEN_W'(1))));
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_issue && (r_issue_rem == LEN_W'(1))) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_finish) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_issue_rem <= '0;
            r_beat_rem  <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_clken     <= 1'b0;
        end else begin
            r_clken    <= 1'b1;
            r_inflight <= w_issue;
            r_done     <= w_finish;
            if (w_accept) begin
                r_addr      <= start_addr;
                r_issue_rem <= length;
                r_beat_rem  <= length;
                r_busy      <= 1'b1;
            end else begin
                if (w_issue) begin
                    r_addr      <= r_addr + ADDR_W'(1);
                    r_issue_rem <= r_issue_rem - LEN_W'(1);
                end
                if (w_pop && (r_beat_rem != '0)) begin
                    r_beat_rem <= r_beat_rem - LEN_W'(1);
                end
                if (w_finish) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

`ifdef ONCHIP_MEM_STREAM_READER_PKT_EN
    // Packet markers travel with the read through the RAM latency.
    logic r_first;
    logic r_inflight_sop;
    logic r_inflight_eop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_first        <= 1'b0;
            r_inflight_sop <= 1'b0;
            r_inflight_eop <= 1'b0;
        end else begin
            r_inflight_sop <= w_issue && r_first;
            r_inflight_eop <= w_issue && (r_issue_rem == LEN_W'(1));
            if (w_accept) begin
                r_first <= 1'b1;
            end else if (w_issue) begin
                r_first <= 1'b0;
            end
        end
    end
`endif

    onchip_mem_stream_reader_skid #(
        .DATA_W    (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (r_inflight),
        .push_data (mem_readdata),
`ifdef ONCHIP_MEM_STREAM_READER_PKT_EN
        .push_sop  (r_inflight_sop),
        .push_eop  (r_inflight_eop),
        .head_sop  (src_startofpacket),
        .head_eop  (src_endofpacket),
`endif
        .pop       (w_pop),
        .count     (w_count),
        .head_data (src_data)
    );

    assign src_valid      = (w_count != '0);
    assign busy           = r_busy;
    assign done           = r_done;
    assign mem_address    = r_addr;
    assign mem_chipselect = w_issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = r_clken;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_onchip_mem_stream_reader
// Description : Self-checking bench for onchip_mem_stream_reader with a
//               behavioural 1-cycle-latency RAM, an expected-beat/address
//               scoreboard and a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_stream_reader;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 11;
    localparam int MEM_WORDS = 1 << ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    logic                clk        = 1'b0;
    logic                reset_n    = 1'b0;
    logic                start      = 1'b0;
    logic [ADDR_W-1:0]   start_addr = '0;
    logic [LEN_W-1:0]    length     = '0;
    logic                src_ready  = 1'b1;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;
    logic [DATA_W-1:0]   src_data;
    logic                src_valid;
`ifdef ONCHIP_MEM_STREAM_READER_PKT_EN
    logic                src_startofpacket;
    logic                src_endofpacket;
`endif

    always #5 clk = ~clk;

    onchip_mem_stream_reader dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .start_addr        (start_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_chipselect    (mem_chipselect),
        .mem_write         (mem_write),
        .mem_byteenable    (mem_byteenable),
        .mem_clken         (mem_clken),
        .mem_readdata      (mem_readdata),
        .src_data          (src_data),
        .src_valid         (src_valid),
`ifdef ONCHIP_MEM_STREAM_READER_PKT_EN
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket),
`endif
        .src_ready         (src_ready)
    );

    // Behavioural RAM: registered address, unregistered data.
    logic [DATA_W-1:0] ram [MEM_WORDS];
    logic [ADDR_W-1:0] ram_addr_q = '0;
    always @(posedge clk) if (mem_clken && mem_chipselect) ram_addr_q <= mem_address;
    assign mem_readdata = ram[ram_addr_q];

    function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
        return 32'hA500_0000 | ({22'd0, a} << 12) | {22'd0, a ^ 10'h3FF};
    endfunction

    int checks = 0, failures = 0;
    int n_cs = 0, n_beats = 0, n_done = 0, n_busy = 0, outst = 0;
    beat_t exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    beat_t mon_e;
    logic [ADDR_W-1:0] mon_a;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    // Ready pattern driver: mode 0 = always ready, mode 1 = 1,0,0,1 repeating.
    int ready_mode = 0;
    int ph = 0;
    logic [3:0] pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            src_ready = pat[ph[1:0]];
            ph = (ph + 1) % 4;
        end else begin
            src_ready = 1'b1;
        end
    end

    // Monitor: samples on the falling edge, between driving and capture.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            outst = 0;
        end else begin
            if (busy) n_busy++;
            if (done) n_done++;
            if (mem_chipselect) begin
                n_cs++;
                outst++;
                checks++;
                if (!busy) begin
                    failures++;
                    $display("FAIL cs_outside_cmd: chipselect=1 busy=%0b required busy=1", busy);
                end
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL cs_unexpected: address=%0h issued with no read expected", mem_address);
                end else begin
                    mon_a = exp_addr_q.pop_front();
                    if (mem_address !== mon_a) begin
                        failures++;
                        $display("FAIL read_address: actual=%0h expected=%0h", mem_address, mon_a);
                    end
                end
            end
            if (prev_stall) begin
                checks++;
                if (!src_valid || (src_data !== prev_data)) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%0b data=%0h expected valid=1 data=%0h",
                             src_valid, src_data, prev_data);
                end
            end
            if (src_valid && src_ready) begin
                n_beats++;
                outst--;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected: data=%0h with empty scoreboard", src_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (src_data !== mon_e.data) begin
                        failures++;
                        $display("FAIL beat_data: actual=%0h expected=%0h", src_data, mon_e.data);
                    end
`ifdef ONCHIP_MEM_STREAM_READER_PKT_EN
                    checks++;
                    if ({src_startofpacket, src_endofpacket} !== {mon_e.sop, mon_e.eop}) begin
                        failures++;
                        $display("FAIL beat_sop_eop: actual=%0b%0b expected=%0b%0b",
                                 src_startofpacket, src_endofpacket, mon_e.sop, mon_e.eop);
                    end
`endif
                end
            end
            checks++;
            if (outst > 2) begin
                failures++;
                $display("FAIL outstanding: actual=%0d required<=2", outst);
            end
            prev_stall = src_valid && !src_ready;
            prev_data  = src_data;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic s, input logic e);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e;
        exp_addr_q.push_back(a);
        exp_q.push_back(b);
    endtask

    task automatic expect_cmd(input logic [ADDR_W-1:0] a, input int len);
        logic [ADDR_W-1:0] ai;
        for (int i = 0; i < len; i++) begin
            ai = a + ADDR_W'(i);
            exp_push(ai, word(ai), i == 0, i == len - 1);
        end
    endtask

    task automatic issue_start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; length = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles from the one after start is sampled; bounded wait for done.
    task automatic wait_done(input int limit, output int bc, output int fv);
        int cyc;
        logic got;
        cyc = 0; bc = 0; fv = -1; got = 1'b0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (busy) bc++;
            if (src_valid && fv < 0) fv = cyc;
            if (done) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles", limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, fv, d0, b0, c0, z0;
        logic seen;
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = word(ADDR_W'(i));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 0);
        chk("reset_done", 64'(done), 0);
        chk("reset_cs", 64'(mem_chipselect), 0);
        chk("reset_valid", 64'(src_valid), 0);
        chk("reset_data", 64'(src_data), 0);
        chk("reset_addr", 64'(mem_address), 0);
        @(negedge clk); reset_n = 1'b1;

        // Basic window, full throughput.
        d0 = n_done;
        exp_push(10'h010, 32'hA501_03EF, 1'b1, 1'b0);
        exp_push(10'h011, 32'hA501_13EE, 1'b0, 1'b0);
        exp_push(10'h012, 32'hA501_23ED, 1'b0, 1'b0);
        exp_push(10'h013, 32'hA501_33EC, 1'b0, 1'b1);
        issue_start(10'h010, 11'd4);
        wait_done(50, bc, fv);
        chk("t1_busy_cycles", 64'(bc), 6);
        chk("t1_first_valid_cycle", 64'(fv), 3);
        repeat (3) @(negedge clk);
        chk("t1_done_pulses", 64'(n_done - d0), 1);
        chk("t1_sb_empty", 64'(exp_q.size()), 0);

        // Address wrap.
        exp_push(10'h3FE, 32'hA53F_E001, 1'b1, 1'b0);
        exp_push(10'h3FF, 32'hA53F_F000, 1'b0, 1'b0);
        exp_push(10'h000, 32'hA500_03FF, 1'b0, 1'b0);
        exp_push(10'h001, 32'hA500_13FE, 1'b0, 1'b1);
        issue_start(10'h3FE, 11'd4);
        wait_done(50, bc, fv);
        chk("t2_busy_cycles", 64'(bc), 6);
        repeat (3) @(negedge clk);
        chk("t2_sb_empty", 64'(exp_q.size()), 0);

        // Backpressure 1,0,0,1.
        b0 = n_beats;
        ready_mode = 1;
        expect_cmd(10'h0F8, 8);
        issue_start(10'h0F8, 11'd8);
        wait_done(200, bc, fv);
        ready_mode = 0;
        repeat (3) @(negedge clk);
        chk("t3_beats", 64'(n_beats - b0), 8);
        chk("t3_sb_empty", 64'(exp_q.size()), 0);

        // Illegal lengths, then length 1.
        c0 = n_cs; d0 = n_done; z0 = n_busy;
        issue_start(10'h020, 11'd0);
        repeat (6) @(negedge clk);
        issue_start(10'h020, 11'd1025);
        repeat (6) @(negedge clk);
        chk("t4_illegal_cs", 64'(n_cs - c0), 0);
        chk("t4_illegal_done", 64'(n_done - d0), 0);
        chk("t4_illegal_busy", 64'(n_busy - z0), 0);
        expect_cmd(10'h155, 1);
        issue_start(10'h155, 11'd1);
        wait_done(50, bc, fv);
        chk("t4_len1_busy_cycles", 64'(bc), 3);
        chk("t4_len1_first_valid", 64'(fv), 3);
        repeat (3) @(negedge clk);
        chk("t4_len1_done", 64'(n_done - d0), 1);
        chk("t4_len1_sb_empty", 64'(exp_q.size()), 0);

        // Reset after 3 of 10 beats.
        b0 = n_beats; d0 = n_done;
        expect_cmd(10'h100, 10);
        issue_start(10'h100, 11'd10);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (n_beats - b0 >= 3) break;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(busy), 0);
        chk("t5_rst_done", 64'(done), 0);
        chk("t5_rst_cs", 64'(mem_chipselect), 0);
        chk("t5_rst_valid", 64'(src_valid), 0);
        chk("t5_rst_data", 64'(src_data), 0);
        chk("t5_rst_addr", 64'(mem_address), 0);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_no_done_on_reset", 64'(n_done - d0), 0);
        expect_cmd(10'h200, 2);
        issue_start(10'h200, 11'd2);
        wait_done(50, bc, fv);
        repeat (3) @(negedge clk);
        chk("t5_after_done", 64'(n_done - d0), 1);
        chk("t5_after_sb_empty", 64'(exp_q.size()), 0);

        // Start held while busy and through the done cycle.
        b0 = n_beats; d0 = n_done; seen = 1'b0;
        expect_cmd(10'h040, 5);
        @(posedge clk); #1;
        start = 1'b1; start_addr = 10'h040; length = 11'd5;
        @(posedge clk); #1;
        start_addr = 10'h300; length = 11'd3;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        chk("t6_done_seen", 64'(seen), 1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_beats", 64'(n_beats - b0), 5);
        chk("t6_done_pulses", 64'(n_done - d0), 1);
        chk("t6_busy_idle", 64'(busy), 0);

        chk("final_sb_empty", 64'(exp_q.size()), 0);
        chk("final_addr_q_empty", 64'(exp_addr_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onchip_mem_stream_reader.md
Name: onchip_mem_stream_reader

Overview:
- Avalon-MM read master that sits directly upstream of the 1024x32 single-port on-chip memory slave; it drives the slave's address, chipselect, write, byteenable and clken pins and consumes its readdata.
- On a start command it streams a contiguous, wrap-around window of memory words out on an Avalon-ST source with valid/ready backpressure.
- Memory read latency is fixed at 1 cycle: address is registered inside the RAM and readdata is unregistered.
- A 2-entry output buffer plus a credit check gives full throughput with no data loss under backpressure.

Parameters:
- ADDR_W, 10: memory word-address width; window addresses wrap modulo 2**ADDR_W.
- DATA_W, 32: memory and stream data width.
- LEN_W, 11 (ADDR_W+1): width of the length field; legal lengths are 1..2**ADDR_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- start_addr  in  ADDR_W  first word address
- length  in  LEN_W  number of words; 0 or >2**ADDR_W means the command is ignored
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last beat is accepted
- mem_address  out  ADDR_W  to slave address
- mem_chipselect  out  1  read strobe
- mem_write  out  1  constant 0
- mem_byteenable  out  DATA_W/8  constant all ones
- mem_clken  out  1  constant 1 out of reset
- mem_readdata  in  DATA_W  slave readdata, valid 1 cycle after chipselect
- src_data  out  DATA_W  stream data
- src_valid  out  1  stream valid
- src_ready  in  1  stream ready; a beat transfers when valid&ready

Behaviour:
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, src_valid=0, src_data=0, FSM=IDLE, buffer empty, inflight=0.
- IDLE:
  - start=1 with 1<=length<=2**ADDR_W: latch addr=start_addr, issue_rem=length, beat_rem=length; go to RUN; busy=1 from the next cycle.
  - An illegal length is ignored: no busy, no done.
- RUN:
  - Read is issued (mem_chipselect=1, mem_address=addr) iff issue_rem>0 and buf_count + inflight - pop < 2, where pop = src_valid & src_ready in this cycle.
  - Each issue: addr<=addr+1 (wraps 2**ADDR_W-1 -> 0), issue_rem--, inflight<=1 for the next cycle.
  - inflight=1: mem_readdata is written into the buffer that cycle.
  - When issue_rem reaches 0, go to DRAIN.
- DRAIN:
  - Once beat_rem reaches 0 (last beat accepted): done=1 for one cycle, busy=0, return to IDLE in the same transition.
- Buffer:
  - 2-entry FIFO; src_valid = buf_count != 0; src_data = head entry.
  - Simultaneous push and pop allowed, including at count 2 (pop frees the slot the push fills).
  - Credit rule guarantees it never overflows.
- Throughput: with src_ready held high, one beat per cycle.
- Latency: first src_valid 2 cycles after start is sampled (issue on cycle +1, data in buffer on cycle +2).
- start while busy: ignored. A start in the same cycle as done is also ignored; the next start is sampled in IDLE.
- Backpressure: src_data and src_valid hold stable while src_valid & !src_ready.
- Reset mid-operation: asynchronous clear to reset values; an in-flight read is discarded and no done is generated.
- mem_chipselect is never asserted outside RUN.

Optional Feature:
- Macro: ONCHIP_MEM_STREAM_READER_PKT_EN.
- Defined: adds outputs src_startofpacket and src_endofpacket.
  - sop is high on the first beat of the command and eop on the last; both on the same beat when length=1.
  - Both are qualified by src_valid, reset to 0, and are stored per buffer entry.
- Undefined: the ports are absent and the buffer stores data only.

Decomposition:
- Shared package: FSM state enum (ST_IDLE, ST_RUN, ST_DRAIN), default ADDR_W/DATA_W/LEN_W constants, and the buffer-depth constant 2.
- One sub-module: onchip_mem_stream_reader_skid, a 2-entry FIFO with push, pop, count, head data and optional sop/eop bits. The FSM and credit logic stay in the top.

Test Plan:
- start_addr=0x010, length=4, src_ready=1: mem_address sequence 0x010..0x013 on consecutive cycles; data words appear back-to-back from cycle +2; done pulses once; busy is high for exactly 6 cycles.
- start_addr=0x3FE, length=4: addresses 0x3FE, 0x3FF, 0x000, 0x001; data matches memory contents in that order.
- length=8, src_ready toggling 1,0,0,1 repeating: no beat lost or duplicated; src_data stable while stalled; the outstanding count never exceeds 2.
- length=0, then length=1025: busy stays 0, no chipselect, no done. Then length=1: a single beat (sop=eop=1 when PKT_EN is defined).
- reset_n pulled low mid-command (after 3 of 10 beats): all outputs return to 0 immediately; after release a new start of length=2 completes normally.
- start asserted while busy and in the done cycle: ignored; the transferred beat count equals the first command's length only.
